// File: rtl/factorial_arbiter.sv
// factorial_arbiter: round-robin sharing of one factorial datapath among
// N_REQ requesters. Each job is sequenced as a start pulse, a settle window
// with fac_done ignored, a wait for fac_done, and a one-cycle ack carrying
// result/err. Operands above MAX_X are rejected; x <= 1 is answered directly.
// Optional macro FACTORIAL_ARB_TIMEOUT_EN: bounds the wait for fac_done to
// TIMEOUT_CYCLES cycles and then acks with err=1.
module factorial_arbiter #(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 32,
    parameter int MAX_X          = 12,
    parameter int START_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic                   busy,
    output logic                   fac_start,
    output logic [WIDTH-1:0]       fac_x,
    input  logic                   fac_done,
    input  logic [WIDTH-1:0]       fac_result
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;

    if (N_REQ < 2 || N_REQ > 8 || START_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("factorial_arbiter: parameter out of range");
    end

    logic [2:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_gnt;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] r_ack;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic             r_fac_start;
    logic [WIDTH-1:0] r_fac_x;

`ifdef FACTORIAL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]    r_wcnt;
`endif

    logic             w_gnt_vld;
    logic [PW-1:0]    w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_x;
    logic [PW-1:0]    w_ptr_nxt;

    // Round-robin search: first set request at or above the pointer, else
    // the first set request from index 0 (wrap).
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_x   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_gnt_vld && req[i] && (i >= 32'(r_ptr))) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(i);
                w_gnt_x   = req_x[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_gnt_vld && req[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(i);
                w_gnt_x   = req_x[i*WIDTH +: WIDTH];
            end
        end
        w_ptr_nxt = (w_gnt_idx == PW'(N_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
    end

    // Job sequencer: grant, start pulse, settle, wait for done, ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_fac_start <= 1'b0;
            r_fac_x     <= '0;
`ifdef FACTORIAL_ARB_TIMEOUT_EN
            r_wcnt      <= '0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt <= w_gnt_idx;
                        r_ptr <= w_ptr_nxt;
                        if (w_gnt_x > WIDTH'(MAX_X)) begin
                            r_state           <= S_ACK;
                            r_ack[w_gnt_idx]  <= 1'b1;
                            r_err             <= 1'b1;
                            r_result          <= '0;
                        end else if (w_gnt_x <= WIDTH'(1)) begin
                            r_state           <= S_ACK;
                            r_ack[w_gnt_idx]  <= 1'b1;
                            r_err             <= 1'b0;
                            r_result          <= WIDTH'(1);
                        end else begin
                            r_state     <= S_START;
                            r_fac_start <= 1'b1;
                            r_fac_x     <= w_gnt_x;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(START_CYCLES - 1)) begin
                        r_fac_start <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SETTLE: begin
                    // fac_done may still be high from the previous job here.
                    if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
`ifdef FACTORIAL_ARB_TIMEOUT_EN
                        r_wcnt  <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (fac_done) begin
                        r_result     <= fac_result;
                        r_err        <= 1'b0;
                        r_ack[r_gnt] <= 1'b1;
                        r_state      <= S_ACK;
                    end
`ifdef FACTORIAL_ARB_TIMEOUT_EN
                    else if (r_wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_result     <= '0;
                        r_err        <= 1'b1;
                        r_ack[r_gnt] <= 1'b1;
                        r_state      <= S_ACK;
                    end else begin
                        r_wcnt <= r_wcnt + TW'(1);
                    end
`endif
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_fac_start <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign result    = r_result;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);
    assign fac_start = r_fac_start;
    assign fac_x     = r_fac_x;

endmodule

// File: tb/tb_factorial_arbiter.sv
// Testbench for factorial_arbiter: factorial datapath model with programmable
// latency and stale-done hold, round-robin reference model, directed and
// randomized job sequences.
module tb_factorial_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXX = 12;
    localparam int SC   = 2;
    localparam int STC  = 3;
    localparam int TO   = 64;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           err;
    logic           busy;
    logic           fac_start;
    logic [W-1:0]   fac_x;
    logic           fac_done;
    logic [W-1:0]   fac_result;

    factorial_arbiter #(
        .N_REQ(N), .WIDTH(W), .MAX_X(MAXX), .START_CYCLES(SC),
        .SETTLE_CYCLES(STC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_x(req_x), .ack(ack),
        .result(result), .err(err), .busy(busy), .fac_start(fac_start),
        .fac_x(fac_x), .fac_done(fac_done), .fac_result(fac_result)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int ptr = 0;
    logic [W-1:0] xs [N];
    int stale_hold = 1;
    int comp_lat = 8;
    bit expect_to = 1'b0;

    function automatic logic [W-1:0] fact(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = 1;
        for (int unsigned i = 2; i <= x; i++) r = r * W'(i);
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Factorial unit model: done stays high from the previous job until
    // stale_hold cycles after a new start, then rises comp_lat cycles after it.
    logic   dp_prev;
    logic   dp_run;
    int     dp_cnt;
    logic [W-1:0] dp_x;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fac_done   <= 1'b0;
            fac_result <= '0;
            dp_prev    <= 1'b0;
            dp_run     <= 1'b0;
            dp_cnt     <= 0;
            dp_x       <= '0;
        end else begin
            dp_prev <= fac_start;
            if (fac_start && !dp_prev) begin
                dp_run <= 1'b1;
                dp_cnt <= 0;
                dp_x   <= fac_x;
            end else if (dp_run) begin
                dp_cnt <= dp_cnt + 1;
                if (dp_cnt + 1 == stale_hold) fac_done <= 1'b0;
                if (dp_cnt + 1 == comp_lat) begin
                    fac_done   <= 1'b1;
                    fac_result <= fact(dp_x);
                    dp_run     <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setx(input int i, input logic [W-1:0] v);
        xs[i] = v;
        req_x[i*W +: W] = v;
    endtask

    // Serve njobs jobs in model grant order; hold keeps acked requests raised.
    task automatic serve(input int njobs, input bit hold, input bit fresh);
        for (int j = 0; j < njobs; j++) begin
            int g;
            int cyc;
            int starts;
            bit seen;
            bit xbad;
            bit comp;
            logic [W-1:0] xv;
            logic [W-1:0] first_fx;
            logic [W-1:0] ers;
            logic eer;
            g = pick(req, ptr);
            if (g < 0) begin
                chk("grant_available", 0, 1);
                return;
            end
            ptr = (g + 1) % N;
            xv = xs[g];
            comp = 1'b0;
            if (xv > MAXX) begin ers = 0; eer = 1'b1; end
            else if (xv <= 1) begin ers = 1; eer = 1'b0; end
            else begin
                comp = 1'b1;
                if (expect_to) begin ers = 0; eer = 1'b1; end
                else begin ers = fact(xv); eer = 1'b0; end
            end
            cyc = 0; starts = 0; seen = 1'b0; xbad = 1'b0; first_fx = '0;
            while (!seen && cyc < 400) begin
                @(negedge clock);
                cyc++;
                if (fac_start) begin
                    if (starts == 0) first_fx = fac_x;
                    starts++;
                end
                if (starts > 0 && fac_x !== first_fx) xbad = 1'b1;
                if (ack !== '0) seen = 1'b1;
            end
            chk("ack_seen", 64'(seen), 1);
            chk("ack_onehot", 64'(ack), 64'(1) << g);
            chk("result", 64'(result), 64'(ers));
            chk("err", 64'(err), 64'(eer));
            chk("start_cycles", 64'(starts), comp ? SC : 0);
            if (comp) begin
                chk("fac_x", 64'(first_fx), 64'(xv));
                chk("fac_x_stable", 64'(xbad), 0);
                if (expect_to && fresh && j == 0) chk("timeout_latency", 64'(cyc), SC + STC + TO + 1);
            end else begin
                chk("bypass_latency", 64'(cyc), (fresh && j == 0) ? 1 : 2);
            end
            if (!hold) req[g] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        req_x = '0;
        for (int i = 0; i < N; i++) xs[i] = '0;
        #1;
        chk("reset_ack", 64'(ack), 0);
        chk("reset_result", 64'(result), 0);
        chk("reset_err", 64'(err), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_fac_start", 64'(fac_start), 0);
        chk("reset_fac_x", 64'(fac_x), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        ptr = 0;
        @(negedge clock);

        // Two simultaneous requests right after reset: req0 first.
        comp_lat = 8;
        setx(0, 9); setx(1, 12);
        req = 4'b0011;
        serve(2, 1'b0, 1'b1);
        @(negedge clock);
        chk("idle_after_ack", 64'(busy), 0);

        // Single x=4 job.
        setx(0, 4);
        req[0] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);
        chk("busy_low_after_ack", 64'(busy), 0);

        // Two continuously held requesters alternate.
        setx(1, 5); setx(2, 5);
        req = 4'b0110;
        serve(4, 1'b1, 1'b1);
        req = '0;
        @(negedge clock);
        @(negedge clock);

        // Reject and bypass.
        setx(3, 13);
        req[3] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);
        setx(3, 0);
        req[3] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);

        // Stale done from the previous job must be ignored during settle.
        stale_hold = 1; comp_lat = 8;
        setx(0, 3);
        req[0] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);
        stale_hold = 4; comp_lat = 9;
        setx(1, 7);
        req[1] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);
        stale_hold = 1;

        // Randomized batches.
        for (int r = 0; r < 12; r++) begin
            logic [N-1:0] m;
            int cnt;
            m = N'($urandom_range(1, (1 << N) - 1));
            cnt = 0;
            for (int i = 0; i < N; i++) begin
                setx(i, W'($urandom_range(0, 14)));
                if (m[i]) cnt++;
            end
            comp_lat = $urandom_range(6, 12);
            req = m;
            serve(cnt, 1'b0, 1'b1);
            @(negedge clock);
            chk("rand_busy_idle", 64'(busy), 0);
        end

        // Reset while waiting for done.
        comp_lat = 100000;
        setx(0, 4);
        req[0] = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clock);
        chk("busy_in_wait", 64'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_ack", 64'(ack), 0);
        chk("midreset_result", 64'(result), 0);
        chk("midreset_err", 64'(err), 0);
        chk("midreset_busy", 64'(busy), 0);
        chk("midreset_fac_start", 64'(fac_start), 0);
        chk("midreset_fac_x", 64'(fac_x), 0);
        req = '0;
        @(negedge clock);
        reset = 1'b0;
        ptr = 0;
        @(negedge clock);
        chk("no_ack_after_reset", 64'(ack), 0);
        comp_lat = 7;
        setx(0, 4);
        req[0] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);

`ifdef FACTORIAL_ARB_TIMEOUT_EN
        comp_lat = 100000;
        expect_to = 1'b1;
        setx(2, 5);
        req[2] = 1'b1;
        serve(1, 1'b0, 1'b1);
        expect_to = 1'b0;
        @(negedge clock);
        comp_lat = 8;
        setx(2, 6);
        req[2] = 1'b1;
        serve(1, 1'b0, 1'b1);
        @(negedge clock);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/factorial_arbiter.md
Name: factorial_arbiter

Overview:
Shares one factorial datapath (start_async / x / done / x_factorial interface) between N_REQ requesters.
- Round-robin arbitration between requesters.
- Sequences each job: start pulse, settle window, wait for done, capture result.
- Returns the result to the winning requester with a one-cycle ack.
- Rejects out-of-range x; bypasses x <= 1 without using the datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width
MAX_X, 12, largest x whose factorial fits in WIDTH bits; larger x rejected
START_CYCLES, 2, cycles fac_start is held high (covers the unit's start synchronizer)
SETTLE_CYCLES, 3, cycles after start during which fac_done is ignored
TIMEOUT_CYCLES, 64, WAIT-state limit (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
req  in  N_REQ  per-requester level request; held until its ack
req_x  in  N_REQ*WIDTH  operand of requester i at bits [i*WIDTH +: WIDTH]; stable while req[i]=1
ack  out  N_REQ  one-hot, one-cycle pulse: job complete for that requester
result  out  WIDTH  factorial; valid with ack, held until next ack
err  out  1  valid with ack: 1 = rejected or timed out
busy  out  1  high in every state except IDLE
fac_start  out  1  drives the factorial unit's start_async
fac_x  out  WIDTH  drives the factorial unit's x
fac_done  in  1  factorial unit done
fac_result  in  WIDTH  factorial unit x_factorial

Behaviour:
- Reset values:
  - ack=0, result=0, err=0, busy=0, fac_start=0, fac_x=0.
  - Round-robin pointer=0; state=IDLE.
- States: IDLE, START, SETTLE, WAIT, ACK.
- IDLE:
  - If any req bit is set, grant the first set bit searching from the pointer upward with wrap.
  - Latch the granted index g and x = req_x[g].
  - Set pointer = (g+1) mod N_REQ.
  - If x > MAX_X: go to ACK with err=1, result=0.
  - Else if x <= 1: go to ACK with err=0, result=1.
  - Else: go to START. Bypass and reject paths never assert fac_start.
- START:
  - fac_start=1 for exactly START_CYCLES cycles.
  - fac_x = latched x; fac_x stays stable from entry to START until WAIT exits.
  - Then go to SETTLE.
- SETTLE: fac_start=0; count SETTLE_CYCLES cycles with fac_done ignored (a stale done from the previous job must not complete this one); then go to WAIT.
- WAIT: on the first cycle with fac_done=1, capture result = fac_result, err=0, and go to ACK.
- ACK: ack[g]=1 for one cycle, then go to IDLE.
  - The requester drops req on the edge where it samples ack.
  - IDLE evaluates req on the following edge, so no double grant.
- Latency, grant edge to ack:
  - Bypass/reject: 1 cycle.
  - Compute: START_CYCLES + SETTLE_CYCLES + (cycles in WAIT) + 1.
- Simultaneous requests: exactly one grant per job. Requests arriving while busy wait. No requester starves; worst-case wait is N_REQ-1 jobs.
- Requests dropped before grant are ignored. Dropping req after grant is illegal (the job still completes and acks).
- Reset mid-operation: immediate return to reset values. The job is lost and no ack is issued. The datapath shares this reset.

Optional Feature:
- Macro: FACTORIAL_ARB_TIMEOUT_EN.
- Defined: a WAIT counter reaches TIMEOUT_CYCLES without fac_done → go to ACK with err=1 and result=0 (fac_result is not captured). The next job proceeds normally.
- Undefined: WAIT waits indefinitely; no counter is synthesized.

Test Plan:
- req[0]=1, x=4 → fac_start high 2 cycles with fac_x=4; ack[0] pulse, result=24, err=0; busy low the cycle after ack.
- req[0], x=9 and req[1], x=12 raised on the same edge after reset → ack[0] first with result=362880, then ack[1] with result=479001600; fac_x never changes during a job.
- req[1] and req[2] held continuously with x=5 → grants alternate 1,2,1,2; each result=120.
- x=13 on req[3] → ack[3] 1 cycle after grant, err=1, result=0, fac_start never asserted; x=0 → result=1, err=0, no fac_start.
- fac_done stuck high from the previous job → not accepted during SETTLE; the new job completes only after done rises again post-settle. Reset asserted in WAIT → all outputs 0 at once, no ack; a following x=4 job gives 24.
- With FACTORIAL_ARB_TIMEOUT_EN: fac_done held 0 → ack after 64 WAIT cycles with err=1, result=0; the next x=6 job gives 720.
